// File: rtl/alu_sequencer.sv
// Issue-side controller for the 8-bit ALU: decodes 16-bit instruction words, strobes the ALU,
// writes results back into a 4x8 register file. Define ALU_SEQ_LDI_EN to make op 101 a load-immediate.
module alu_sequencer #(
  parameter logic [7:0] REG_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [7:0]  alu_imm,
  output logic [2:0]  alu_control,
  output logic        alu_execute,
  input  logic [7:0]  alu_out,
  input  logic        alu_zf,
  input  logic        alu_cf,
  output logic        zf,
  output logic        cf,
  output logic        done_valid,
  output logic [7:0]  done_data,
  output logic        illegal,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  dbg_data
);

  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_CMP = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, WB, LDI} state_t;

  state_t      state_q, state_d;
  logic        accept;
  logic [2:0]  op_q;
  logic        wb_q;
  logic [1:0]  rd_q;
  logic [7:0]  imm_q;
  logic [7:0]  regs [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid && instr_ready) begin
          accept  = 1'b1;
          state_d = (instr[15:13] == OP_LDI) ? LDI : EXEC;
        end
      end
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      LDI:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // instr_ready tracks the state being entered, so it is low only while an instruction is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_ready <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_imm     <= '0;
      alu_control <= '0;
      alu_execute <= 1'b0;
      zf          <= 1'b0;
      cf          <= 1'b0;
      done_valid  <= 1'b0;
      done_data   <= '0;
      illegal     <= 1'b0;
      op_q        <= '0;
      wb_q        <= 1'b0;
      rd_q        <= '0;
      imm_q       <= '0;
      for (int unsigned i = 0; i < 4; i++) regs[i] <= REG_RESET;
    end else begin
      instr_ready <= (state_d == IDLE);
      alu_execute <= 1'b0;
      done_valid  <= 1'b0;
      if (accept) begin
        op_q  <= instr[15:13];
        wb_q  <= instr[12];
        rd_q  <= instr[11:10];
        imm_q <= instr[7:0];
        if (instr[15:13] != OP_LDI) begin
          alu_a       <= regs[instr[11:10]];
          alu_b       <= regs[instr[9:8]];
          alu_imm     <= instr[7:0];
          alu_control <= instr[15:13];
          alu_execute <= 1'b1;
        end
      end
      if (state_q == WB) begin
        if (wb_q) regs[rd_q] <= alu_out;
        if (op_q == OP_CMP) begin
          zf <= alu_zf;
          cf <= alu_cf;
        end
        done_valid <= 1'b1;
        done_data  <= alu_out;
        illegal    <= 1'b0;
      end
      if (state_q == LDI) begin
        done_valid <= 1'b1;
        done_data  <= imm_q;
`ifdef ALU_SEQ_LDI_EN
        regs[rd_q] <= imm_q;
        illegal    <= 1'b0;
`else
        illegal    <= 1'b1;
`endif
      end
    end
  end

  assign dbg_data = regs[dbg_sel];

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Issue-side controller for the 8-bit ALU: accepts 16-bit instruction words over a valid/ready handshake, decodes them, drives the ALU operand/control/execute inputs, captures the registered ALU result one cycle later and writes it back into a 4-entry 8-bit register file. Sits between the instruction source (fetch logic or testbench) and the ALU, owning the architectural registers and the committed Z/C flags.

## Interface
- REG_RESET, 8'h00, value loaded into all four registers on reset
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction word offered
- instr_ready  out  1  sequencer can accept a word this cycle
- instr  in  16  [15:13] op, [12] wb (write-back enable), [11:10] rd/ra, [9:8] rb, [7:0] imm
- alu_a  out  8  ALU operand A (= reg[ra])
- alu_b  out  8  ALU operand B (= reg[rb])
- alu_imm  out  8  ALU immediate (shift amount)
- alu_control  out  3  ALU operation code (= op)
- alu_execute  out  1  one-cycle ALU execute strobe
- alu_out  in  8  registered ALU result
- alu_zf, alu_cf  in  1  registered ALU flags
- zf, cf  out  1  committed flags
- done_valid  out  1  one-cycle completion pulse
- done_data  out  8  value written (or that would be written) by the completed instruction
- illegal  out  1  qualifies done_valid: instruction was rejected
- dbg_sel  in  2  register-file read select
- dbg_data  out  8  reg[dbg_sel], combinational

## Operation
- States: IDLE, EXEC, WB, LDI. All outputs except dbg_data registered.
- IDLE: instr_ready=1. On instr_valid & instr_ready edge: latch instr, instr_ready<=0.
  - op != 101: alu_a/alu_b/alu_imm/alu_control loaded from regs/instr, alu_execute<=1, -> EXEC.
  - op == 101: -> LDI (see Configuration); no ALU strobe.
- EXEC: alu_execute<=0 at exit edge (high exactly one cycle); ALU registers its result on this edge; -> WB. alu_a/b/imm/control hold their values until next accept.
- WB: at exit edge: if wb, reg[rd]<=alu_out; if op==111, zf<=alu_zf, cf<=alu_cf (regardless of wb, so wb=0 gives CMP); done_valid<=1, done_data<=alu_out, illegal<=0, instr_ready<=1; -> IDLE.
- LDI: at exit edge: reg[rd]<=imm (wb ignored), done_valid<=1, done_data<=imm; -> IDLE.
- done_valid clears on the following edge. Flags only change for op 111.
- rd and ra share a field: destination is always operand A's register.

## Timing
- Reset (async, immediate): state IDLE, instr_ready=0, alu_execute=0, alu_a/b/imm=0, alu_control=0, zf=cf=0, done_valid=0, done_data=0, illegal=0, regs=REG_RESET. instr_ready rises at first rising edge with rst_n high.
- ALU ops: accept edge T0; alu_execute high T0..T1; write-back edge T2; done_valid and instr_ready high T2..T3; earliest next accept T3. Throughput 1 per 3 cycles.
- LDI: accept T0, write T1, done T1..T2, next accept T2.
- instr_valid while instr_ready=0 ignored; source must hold word until accepted.
- No hazards: operands read at accept edge, after any prior write-back.
- dbg_data shows old value in the write-back cycle, new value after the edge.
- Reset mid-instruction aborts it: no write, no done pulse, alu_execute drops immediately. ALU itself has no reset; sequencer never samples alu_out except in WB.

## Configuration
- ALU_SEQ_LDI_EN defined: op 101 is load-immediate as described.
- Undefined: op 101 is illegal; IDLE -> LDI still taken, but no register write, done_valid=1 with illegal=1, done_data=imm; flags unchanged.

## Test plan
- Reset release: all outputs at reset values, instr_ready=0 then 1 after first edge; dbg_data=REG_RESET for all sel.
- LDI r1=0x05, LDI r2=0x03 (LDI_EN), then ADD r1,r2 wb=1 -> alu_execute pulse exactly 1 cycle with a=05,b=03,control=110; done_data=0x08, reg1=0x08 on dbg.
- SUB r1(0x03),r2(0x05) wb=0 -> reg1 stays 0x03, zf=0, cf=1; SUB r2,r2 wb=1 -> reg2=0x00, zf=1, cf=0.
- SHR r1=0x80 imm=3 wb=1 -> reg1=0x10; flags unchanged from previous op.
- Back-to-back instr_valid held high: accepts exactly every 3 cycles (2 for LDI), no extra strobes.
- Assert rst_n low during EXEC -> no write, no done pulse; without LDI_EN op 101 -> illegal=1 pulse, register unchanged.
